// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with variable-latency memory, decode handshake and branch redirect
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_base,
   input  logic [31:0] redirect_imm,
   output logic        fetch_fault
);
   typedef enum logic [2:0] {FETCH, WAIT, HOLD, DRAIN, HALT} state_t;
   state_t state, state_nxt;
   logic [31:0] pc, target;
   logic accept, redir, misaligned;
   // the immediate counts halfwords, so the shift turns it into a byte offset
   assign target = redirect_base + (redirect_imm << 1);
   assign misaligned = |target[1:0];
   assign redir = redirect_valid && state != HALT;
   assign accept = imem_req_valid && imem_req_ready;
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= FETCH;
      else state <= state_nxt;
   // next state: a redirect outranks every other event; a request already in flight forces DRAIN
   always_comb begin
      state_nxt = state;
      if (redir)
         state_nxt = misaligned ? HALT :
                     (state == FETCH) ? (accept ? DRAIN : FETCH) :
                     (state == WAIT) ? (imem_resp_valid ? FETCH : DRAIN) :
                     (state == HOLD) ? FETCH : DRAIN;
      else
         case (state)
            FETCH: state_nxt = accept ? WAIT : FETCH;
            WAIT: state_nxt = imem_resp_valid ? HOLD : WAIT;
            HOLD: state_nxt = inst_ready ? FETCH : HOLD;
            DRAIN: state_nxt = imem_resp_valid ? FETCH : DRAIN;
            default: state_nxt = state;
         endcase
   end
   // request outputs decode straight from state and pc; held low while reset is asserted
   always_comb begin
      imem_req_valid = (state == FETCH) && !rst;
      imem_addr = pc;
   end
   // pc and the registered decode-facing outputs
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pc <= RESET_PC;
         inst <= '0;
         inst_pc <= '0;
         inst_valid <= 1'b0;
         fetch_fault <= 1'b0;
      end else if (redir) begin
         inst_valid <= 1'b0;
         if (misaligned) fetch_fault <= 1'b1;
         else pc <= target;
      end else if (state == WAIT && imem_resp_valid) begin
         inst <= imem_resp_data;
         inst_pc <= pc;
         inst_valid <= 1'b1;
         pc <= pc + 32'd4;
      end else if (state == HOLD && inst_ready) begin
         inst_valid <= 1'b0;
      end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a latency-controlled memory model
module tb_fetch_unit;
   logic clk = 1'b0;
   logic rst;
   logic imem_req_valid, imem_req_ready;
   logic [31:0] imem_addr;
   logic imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic inst_valid, inst_ready;
   logic [31:0] inst, inst_pc;
   logic redirect_valid;
   logic [31:0] redirect_base, redirect_imm;
   logic fetch_fault;
   int total = 0;
   int bad = 0;
   int n_req = 0;
   int n_inst = 0;
   int mem_lat = 0;
   logic [31:0] poison_addr = 32'hFFFF_FFFF;
   logic [31:0] exp_addr[$];
   logic [63:0] exp_inst[$];

   fetch_unit #(.RESET_PC(32'h100)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
      .redirect_valid(redirect_valid), .redirect_base(redirect_base), .redirect_imm(redirect_imm),
      .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mw(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic wait_inst(input int n);
      int b = 0;
      while (n_inst < n && b < 200) begin tick; b++; end
      chk("inst_count", n_inst, n);
   endtask

   task automatic wait_req(input int n);
      int b = 0;
      while (n_req < n && b < 200) begin tick; b++; end
      chk("req_count", n_req, n);
   endtask

   task automatic wait_valid;
      int b = 0;
      while (!inst_valid && b < 200) begin tick; b++; end
      chk("hold_reached", {31'b0, inst_valid}, 1);
   endtask

   task automatic push_fetch(input logic [31:0] a);
      exp_addr.push_back(a);
      exp_inst.push_back({mw(a), a});
   endtask

   // memory: one response per accepted request, mem_lat extra cycles after the WAIT cycle
   initial begin
      logic pend;
      int cnt;
      logic [31:0] paddr;
      pend = 0; cnt = 0; paddr = '0;
      imem_resp_valid = 0;
      imem_resp_data = '0;
      forever begin
         @(negedge clk);
         #2;
         imem_resp_valid = 0;
         if (pend) begin
            if (cnt == 0) begin
               imem_resp_valid = 1;
               imem_resp_data = (paddr == poison_addr) ? 32'hDEAD_BEEF : mw(paddr);
               pend = 0;
            end else cnt--;
         end
         if (imem_req_valid && imem_req_ready) begin
            pend = 1; cnt = mem_lat; paddr = imem_addr;
         end
      end
   end

   // monitor: checks every accepted request and every delivered instruction against the scoreboard
   initial begin
      logic [31:0] a;
      logic [63:0] e;
      forever begin
         @(negedge clk);
         #3;
         if (!rst) begin
            if (imem_req_valid && imem_req_ready) begin
               n_req++;
               if (exp_addr.size() == 0) chk("req_unexpected", imem_addr, 32'hXXXX_XXXX);
               else begin a = exp_addr.pop_front(); chk("req_addr", imem_addr, a); end
            end
            if (inst_valid) chk("no_stale_word", {31'b0, inst == 32'hDEAD_BEEF}, 0);
            if (inst_valid && inst_ready && !redirect_valid) begin
               n_inst++;
               if (exp_inst.size() == 0) chk("inst_unexpected", inst_pc, 32'hXXXX_XXXX);
               else begin
                  e = exp_inst.pop_front();
                  chk("inst_word", inst, e[63:32]);
                  chk("inst_pc", inst_pc, e[31:0]);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1; imem_req_ready = 0; inst_ready = 1;
      redirect_valid = 0; redirect_base = '0; redirect_imm = '0;
      tick; tick;
      chk("rst_req_valid", {31'b0, imem_req_valid}, 0);
      chk("rst_inst_valid", {31'b0, inst_valid}, 0);
      chk("rst_inst", inst, 0);
      chk("rst_inst_pc", inst_pc, 0);
      chk("rst_fault", {31'b0, fetch_fault}, 0);
      chk("rst_addr", imem_addr, 32'h100);
      rst = 0;
      // straight-line fetch with zero-wait memory
      push_fetch(32'h100); push_fetch(32'h104); push_fetch(32'h108);
      imem_req_ready = 1;
      wait_inst(3);
      imem_req_ready = 0;
      // decode stall in HOLD
      inst_ready = 0;
      exp_addr.push_back(32'h10C);
      imem_req_ready = 1;
      wait_valid;
      imem_req_ready = 0;
      exp_inst.push_back({mw(32'h10C), 32'h10C});
      imem_req_ready = 1;
      repeat (5) begin
         tick;
         chk("stall_inst", inst, mw(32'h10C));
         chk("stall_pc", inst_pc, 32'h10C);
         chk("stall_no_req", {31'b0, imem_req_valid}, 0);
      end
      push_fetch(32'h110);
      inst_ready = 1;
      wait_inst(n_inst + 2);
      imem_req_ready = 0;
      // redirect while waiting on a slow response that must be discarded
      poison_addr = 32'h114; mem_lat = 2;
      exp_addr.push_back(32'h114);
      imem_req_ready = 1;
      wait_req(n_req + 1);
      imem_req_ready = 0;
      redirect_valid = 1; redirect_base = 32'h200; redirect_imm = 32'hFFFF_FFF8;
      tick;
      redirect_valid = 0;
      chk("wait_redir_addr", imem_addr, 32'h1F0);
      chk("drain_no_req", {31'b0, imem_req_valid}, 0);
      repeat (4) tick;
      mem_lat = 0;
      push_fetch(32'h1F0);
      imem_req_ready = 1;
      wait_inst(n_inst + 1);
      imem_req_ready = 0;
      // redirect in HOLD with decode accepting in the same cycle
      inst_ready = 0;
      exp_addr.push_back(32'h1F4);
      imem_req_ready = 1;
      wait_valid;
      imem_req_ready = 0;
      inst_ready = 1;
      redirect_valid = 1; redirect_base = 32'h40; redirect_imm = 32'h10;
      tick;
      redirect_valid = 0;
      chk("hold_redir_drop", {31'b0, inst_valid}, 0);
      chk("hold_redir_addr", imem_addr, 32'h60);
      chk("hold_redir_req", {31'b0, imem_req_valid}, 1);
      push_fetch(32'h60);
      imem_req_ready = 1;
      wait_inst(n_inst + 1);
      imem_req_ready = 0;
      // misaligned target halts the unit until reset
      redirect_valid = 1; redirect_base = 32'h0; redirect_imm = 32'h1;
      tick;
      chk("fault_set", {31'b0, fetch_fault}, 1);
      chk("fault_inst_valid", {31'b0, inst_valid}, 0);
      redirect_base = 32'h80; redirect_imm = 32'h0;
      imem_req_ready = 1;
      tick;
      redirect_valid = 0;
      repeat (20) begin
         tick;
         chk("halt_no_req", {31'b0, imem_req_valid}, 0);
      end
      chk("fault_sticky", {31'b0, fetch_fault}, 1);
      imem_req_ready = 0;
      rst = 1;
      #1;
      chk("fault_cleared", {31'b0, fetch_fault}, 0);
      chk("fault_rst_addr", imem_addr, 32'h100);
      tick;
      rst = 0;
      push_fetch(32'h100);
      imem_req_ready = 1;
      wait_inst(n_inst + 1);
      imem_req_ready = 0;
      // asynchronous reset in the middle of WAIT, response arrives after release
      mem_lat = 3;
      exp_addr.push_back(32'h104);
      imem_req_ready = 1;
      wait_req(n_req + 1);
      imem_req_ready = 0;
      rst = 1;
      #1;
      chk("async_req_valid", {31'b0, imem_req_valid}, 0);
      chk("async_inst_valid", {31'b0, inst_valid}, 0);
      chk("async_inst_pc", inst_pc, 0);
      chk("async_addr", imem_addr, 32'h100);
      tick;
      rst = 0;
      repeat (6) tick;
      chk("late_resp_ignored", {31'b0, inst_valid}, 0);
      mem_lat = 0;
      push_fetch(32'h100);
      imem_req_ready = 1;
      wait_inst(n_inst + 1);
      imem_req_ready = 0;
      repeat (3) tick;
      chk("req_queue_empty", exp_addr.size(), 0);
      chk("inst_queue_empty", exp_inst.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
